// File: rtl/arc_muldiv_pkg.sv
// arc_muldiv_pkg: shared states, op kinds and funct codes for the mult/div sequencer.
package arc_muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
endpackage

// File: rtl/muldiv_step_unit.sv
// muldiv_step_unit: one shift-add multiply step or one restoring-divide step on a {upper,lower} partial.
module muldiv_step_unit
  import arc_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] part,
  input  logic [WIDTH-1:0]   operand,
  input  op_t                op,
  output logic [2*WIDTH-1:0] part_nx,
  output logic               q_bit
);
  logic [WIDTH:0] sum, diff;
  always_comb begin
    sum = {1'b0, part[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{part[0]}} & operand};
    diff = part[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    // a shifted remainder that overflowed WIDTH bits always exceeds the divisor (matters for divide by zero)
    q_bit = op == OP_DIV && (part[2*WIDTH-1] || !diff[WIDTH]);
    part_nx = op == OP_MUL ? {sum, part[WIDTH-1:1]}
            : {q_bit ? diff[WIDTH-1:0] : part[2*WIDTH-2:WIDTH-1], part[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MIPS MULT/DIV sequencer owning HI/LO, with pipeline stall.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module muldiv_sequencer
  import arc_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_con_Valid,
  input  logic [5:0]       i_con_FuncCode,
  input  logic             i_con_Flush,
  input  logic [WIDTH-1:0] i_dat_Rs,
  input  logic [WIDTH-1:0] i_dat_Rt,
  output logic             o_con_Stall,
  output logic             o_con_Busy,
  output logic             o_con_Done,
  output logic [WIDTH-1:0] o_dat_HiLo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  op_t op;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] b, hi, lo, a_in, b_in, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] p, p_nx;
  logic q_bit, start, mt_wr;
  assign start = state == IDLE && i_con_Valid && !i_con_Flush
              && i_con_FuncCode inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign mt_wr = state == IDLE && i_con_Valid && !i_con_Flush
              && i_con_FuncCode inside {F_MTHI, F_MTLO};
`ifdef MULDIV_SIGNED_EN
  logic sgn_op, sa, sb, sa_in, sb_in;
  logic [2*WIDTH-1:0] prod;
  assign sgn_op = i_con_FuncCode == F_MULT || i_con_FuncCode == F_DIV;
  assign sa_in = sgn_op && i_dat_Rs[WIDTH-1];
  assign sb_in = sgn_op && i_dat_Rt[WIDTH-1];
  assign a_in = sa_in ? -i_dat_Rs : i_dat_Rs;
  assign b_in = sb_in ? -i_dat_Rt : i_dat_Rt;
  always_comb begin
    prod = (sa ^ sb) ? -p : p;
    fix_hi = op == OP_MUL ? prod[2*WIDTH-1:WIDTH] : sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    fix_lo = op == OP_MUL ? prod[WIDTH-1:0] : (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  end
`else
  assign a_in = i_dat_Rs;
  assign b_in = i_dat_Rt;
  assign fix_hi = p[2*WIDTH-1:WIDTH];
  assign fix_lo = p[WIDTH-1:0];
`endif
  muldiv_step_unit #(.WIDTH(WIDTH)) u_step (
    .part(p), .operand(b), .op(op), .part_nx(p_nx), .q_bit(q_bit)
  );
  always_comb begin
    state_nx = i_con_Flush && state != IDLE ? IDLE
             : state == IDLE ? (start ? RUN : IDLE)
             : state == RUN  ? (count == '0 ? FIXUP : RUN)
             : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      op <= OP_MUL;
      count <= '0;
      b <= '0;
      p <= '0;
      hi <= '0;
      lo <= '0;
`ifdef MULDIV_SIGNED_EN
      sa <= 1'b0;
      sb <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (start) begin
        op <= i_con_FuncCode[1] ? OP_DIV : OP_MUL;
        count <= CW'(WIDTH - 1);
        b <= b_in;
        p <= {{WIDTH{1'b0}}, a_in};
`ifdef MULDIV_SIGNED_EN
        sa <= sa_in;
        sb <= sb_in;
`endif
      end else if (state == RUN) begin
        p <= p_nx | {{(2*WIDTH-1){1'b0}}, q_bit};
        count <= i_con_Flush || count == '0 ? '0 : count - CW'(1);
      end
      if (state == FIXUP && !i_con_Flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (mt_wr) begin
        if (i_con_FuncCode == F_MTHI) hi <= i_dat_Rs;
        if (i_con_FuncCode == F_MTLO) lo <= i_dat_Rs;
      end
    end
  end
  assign o_con_Busy = state != IDLE;
  assign o_con_Stall = start || o_con_Busy;
  assign o_con_Done = state == FIXUP && !i_con_Flush;
  assign o_dat_HiLo = !i_con_Valid || o_con_Busy ? '0
                    : i_con_FuncCode == F_MFHI ? hi
                    : i_con_FuncCode == F_MFLO ? lo : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table plus hand-written flush/reset/stall sequences for muldiv_sequencer.
module tb_muldiv_sequencer;
  import arc_muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, valid = 0, flush = 0;
  logic [5:0] funct = 0;
  logic [W-1:0] rs = 0, rt = 0;
  logic stall, busy, done;
  logic [W-1:0] hilo;
  typedef struct {logic [5:0] f; logic [W-1:0] a, b, hi, lo;} vec_t;
  typedef struct {logic [W-1:0] hi, lo;} res_t;
  res_t exp_q[$];
  res_t cur;
  vec_t vecs[13];
  int n_chk = 0, n_pass = 0;
  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_Valid(valid), .i_con_FuncCode(funct),
    .i_con_Flush(flush), .i_dat_Rs(rs), .i_dat_Rt(rt), .o_con_Stall(stall),
    .o_con_Busy(busy), .o_con_Done(done), .o_dat_HiLo(hilo)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic read_hilo(string tag, logic [W-1:0] ehi, logic [W-1:0] elo);
    valid = 1; funct = F_MFHI; #1;
    chk({tag, " mfhi"}, hilo, ehi);
    chk({tag, " mfhi stall"}, 32'(stall), 0);
    @(negedge clk); funct = F_MFLO; #1;
    chk({tag, " mflo"}, hilo, elo);
    @(negedge clk); valid = 0;
  endtask
  task automatic mt(logic [W-1:0] h, logic [W-1:0] l);
    valid = 1; funct = F_MTHI; rs = h; #1;
    chk("mthi stall", 32'(stall), 0);
    @(negedge clk); funct = F_MTLO; rs = l;
    @(negedge clk); valid = 0;
  endtask
  task automatic run_mdu(string tag, logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] ehi, logic [W-1:0] elo, bit mf_busy);
    int cyc = 0, low = 0;
    bit seen = 0;
    exp_q.push_back('{ehi, elo});
    valid = 1; funct = f; rs = a; rt = b; #1;
    chk({tag, " accept stall"}, 32'(stall), 1);
    while (!seen && cyc < W + 8) begin
      @(negedge clk); cyc++;
      if (mf_busy && cyc == 1) funct = F_MFHI;
      #1;
      if (!stall) low++;
      if (done) begin
        seen = 1;
        cur = exp_q.pop_front();
      end
    end
    if (!seen && exp_q.size() > 0) cur = exp_q.pop_front();
    chk({tag, " done cycle"}, 32'(cyc), W + 1);
    chk({tag, " stall low while busy"}, 32'(low), 0);
    @(negedge clk);
    if (mf_busy) begin
      #1;
      chk({tag, " mfhi after busy"}, hilo, cur.hi);
      chk({tag, " mfhi stall release"}, 32'(stall), 0);
    end
    valid = 0; #1;
    chk({tag, " done single pulse"}, 32'(done), 0);
    chk({tag, " idle after op"}, 32'(busy), 0);
    read_hilo(tag, cur.hi, cur.lo);
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[2]  = '{F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[3]  = '{F_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0};
    vecs[4]  = '{F_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[5]  = '{F_DIVU,  32'd7,        32'd100,      32'd7,        32'd0};
    vecs[6]  = '{F_DIVU,  32'h80000000, 32'h80000000, 32'd0,        32'd1};
    vecs[7]  = '{F_MULTU, 32'h00010001, 32'h00010001, 32'd1,        32'h00020001};
    vecs[8]  = '{F_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[9]  = '{F_MULT,  32'd3,        32'd5,        32'd0,        32'd15};
`ifdef MULDIV_SIGNED_EN
    vecs[10] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[11] = '{F_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
`else
    vecs[10] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC};
    vecs[11] = '{F_MULT,  32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE};
`endif
    vecs[12] = '{F_MULTU, 32'd0,        32'hDEADBEEF, 32'd0,        32'd0};
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset stall", 32'(stall), 0);
    rst_n = 1;
    @(negedge clk);
    read_hilo("reset", 0, 0);
    mt(32'hA5A5A5A5, 32'h5A5A5A5A);
    read_hilo("mt", 32'hA5A5A5A5, 32'h5A5A5A5A);
    valid = 1; funct = 6'd32; rs = 32'h1234; #1;
    chk("other funct stall", 32'(stall), 0);
    chk("other funct hilo", hilo, 0);
    @(negedge clk); #1;
    chk("other funct busy", 32'(busy), 0);
    valid = 0;
    foreach (vecs[i]) run_mdu($sformatf("v%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);
    run_mdu("mfhi busy", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    mt(32'h1111, 32'h2222);
    valid = 1; funct = F_MULT; rs = 3; rt = 5;
    repeat (10) @(negedge clk);
    flush = 1; #1;
    chk("flush busy before", 32'(busy), 1);
    chk("flush no done", 32'(done), 0);
    @(negedge clk); flush = 0; valid = 0; #1;
    chk("flush idle", 32'(busy), 0);
    chk("flush stall", 32'(stall), 0);
    begin
      int d = 0;
      repeat (40) begin @(negedge clk); #1; if (done) d++; end
      chk("flush done count", 32'(d), 0);
    end
    read_hilo("flush", 32'h1111, 32'h2222);
    valid = 1; funct = F_DIVU; rs = 9; rt = 3; flush = 1; #1;
    chk("flush accept stall", 32'(stall), 0);
    @(negedge clk); flush = 0; valid = 0; #1;
    chk("flush accept busy", 32'(busy), 0);
    valid = 1; funct = F_MULTU; rs = 7; rt = 9;
    repeat (5) @(negedge clk);
    valid = 0; rst_n = 0; #1;
    chk("midop reset busy", 32'(busy), 0);
    chk("midop reset stall", 32'(stall), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    read_hilo("midop reset", 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
